keypad_scan: RTL and testbench
==============================

Name: keypad_scan

Overview:
- Bus-attached 4x4 hex keypad reader; the input-side counterpart of the 7-segment display driver.
- Drives keypad rows one at a time, active-low, and samples the column lines.
- Debounces the 16-key state and encodes each new key press as a 4-bit hex code into a small FIFO.
- Software reads the FIFO over the same strobe/ack/rw/addr peripheral bus used by the display block; an optional level interrupt flags pending keys.

Parameters:
- CNT_BITS, 16: one row period is 2^CNT_BITS clocks; one full scan is 4 row periods.
- DEBOUNCE, 3: number of consecutive identical full scans required before the debounced state updates (1..15).
- FIFO_LOG, 2: FIFO depth is 2^FIFO_LOG entries.
- REPEAT_DELAY, 32: full scans before the first auto-repeat; used only with KEYPAD_REPEAT_EN.
- REPEAT_RATE, 8: full scans between repeats; used only with KEYPAD_REPEAT_EN.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- strobe  in  1  bus access request, one access per asserted cycle.
- rw  in  1  1 = write, 0 = read.
- addr  in  32  register select; only addr[1:0] are decoded.
- d_in  in  32  write data.
- d_out  out  32  read data, registered.
- ack  out  1  access acknowledge.
- row  out  4  keypad row drive; one-hot low.
- col  in  4  keypad column sense; active-low, externally pulled up.
- irq  out  1  level interrupt.

Behaviour:
- Reset (reset=0, asynchronous assert, release synchronous to clk):
  - Outputs: d_out=0, ack=0, row=4'b1110, irq=0.
  - State: prescaler, row index, debounce count, raw/debounced vectors, FIFO, overflow flag and irq_en all cleared.
  - Reset mid-scan or mid-access abandons the operation with no partial push.
- Column synchronisation:
  - col passes through a 2-flop synchroniser, then is inverted so that 1 = pressed.
- Scanning:
  - Prescaler counts 0..2^CNT_BITS-1 and wraps.
  - On the wrap cycle, synchronised columns are stored into raw[row_idx*4 +: 4], and row_idx advances mod 4.
  - row = ~(1<<row_idx), registered.
  - Key code = row_idx*4 + col_idx.
- Debounce, evaluated at the end of each full scan (row_idx wraps 3->0):
  - If raw equals the previous snapshot, stable_cnt increments, saturating at DEBOUNCE; otherwise stable_cnt=0.
  - On the cycle stable_cnt first reaches DEBOUNCE, raw is compared with the debounced vector `deb`:
    - new = raw & ~deb; deb <= raw.
    - If new != 0, push the lowest set index of `new`. Other simultaneous presses are not queued but remain visible in `deb`.
  - Releases never push.
- FIFO:
  - Push when full with no pop: data dropped, overflow <= 1 (sticky).
  - Push and pop in the same cycle: both performed, count unchanged, no overflow, even when full.
  - Pop when empty: no state change.
- Bus access:
  - ack <= strobe every cycle, so ack follows strobe by 1 cycle.
  - d_out is updated only on read strobes and holds otherwise.
- Read map:
  - addr 0: {valid, 27'b0, code[3:0]}. valid=1 if the FIFO is non-empty, and that read pops the head. Empty read returns 0.
  - addr 1: {15'b0, irq_en, 7'b0, overflow, 5'b0, count[FIFO_LOG:0]}, with count zero-extended to 3 bits.
  - addr 2: {16'b0, deb}.
  - addr 3: 0.
- Write map:
  - addr 0: flush FIFO (count=0). Overrides a push in the same cycle.
  - addr 1: d_in[8]=1 clears overflow (a clear and a new overflow in the same cycle leaves overflow=1); irq_en <= d_in[16].
  - addr 2, addr 3: ignored.
- irq: registered, irq = irq_en & (count != 0); reflects FIFO state one cycle after the change.

Optional Feature:
- KEYPAD_REPEAT_EN defined (auto-repeat):
  - Applies while deb has exactly one bit set and is unchanged.
  - A scan counter re-pushes that key after REPEAT_DELAY full scans, then every REPEAT_RATE scans.
  - The counter resets whenever deb changes.
  - Repeat pushes obey the same full/overflow rules.
- Undefined: no repeat logic is synthesised; a held key produces exactly one push.

Test Plan (CNT_BITS=2, DEBOUNCE=2, FIFO_LOG=2):
- Key 0x9 (row 2, col 1) held low -> one push after debounce; read addr 0 returns 0x80000009; next read returns 0; ack high 1 cycle after each strobe.
- Col line toggling every full scan -> no push, deb stays 0. Then held stable 2 scans -> exactly one push.
- Press and release 5 distinct keys with no reads -> count=4, overflow=1 in addr 1 read (0x00000104); write addr 1 d_in=0x100 -> overflow=0; the four oldest codes read back in order.
- Full FIFO, read strobe coinciding with a push cycle -> count stays 4, overflow stays 0.
- irq_en=1 via write 0x10000 to addr 1, then a key press -> irq rises 1 cycle after push. Write addr 0 (flush) -> irq falls the next cycle.
- reset pulsed low mid-scan with a key held -> row=4'b1110, d_out=0, FIFO empty immediately. The key is re-detected as a single new press after reset releases.

Source files
------------

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 hex keypad scanner with debounce, key-code FIFO and bus read-out.
// Optional auto-repeat of a single held key is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scan #(
  parameter int unsigned CNT_BITS     = 16,
  parameter int unsigned DEBOUNCE     = 3,
  parameter int unsigned FIFO_LOG     = 2,
  parameter int unsigned REPEAT_DELAY = 32,
  parameter int unsigned REPEAT_RATE  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        strobe,
  input  logic        rw,
  input  logic [31:0] addr,
  input  logic [31:0] d_in,
  output logic [31:0] d_out,
  output logic        ack,
  output logic [3:0]  row,
  input  logic [3:0]  col,
  output logic        irq
);

  localparam int unsigned Depth = 2 ** FIFO_LOG;
  localparam logic [FIFO_LOG:0] FullCount = {1'b1, {FIFO_LOG{1'b0}}};

  function automatic logic [3:0] lowest_idx(input logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  logic [3:0]          col_meta_q, col_sync_q;
  logic [CNT_BITS-1:0] presc_q, presc_d;
  logic [1:0]          row_idx_q, row_idx_d;
  logic [3:0]          row_q, row_d;
  logic [15:0]         raw_q, raw_d, snap_q, snap_d, deb_q, deb_d;
  logic [3:0]          stable_q, stable_d;
  logic                wrap, scan_end, new_push;
  logic [3:0]          new_code;
  logic                push_req;
  logic [3:0]          push_code;

  logic [3:0]          mem_q [Depth];
  logic [FIFO_LOG-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_LOG:0]   count_q, count_d;
  logic                ovf_q, ovf_d, irq_en_q, irq_en_d, irq_q, irq_d, ack_q, ack_d;
  logic [31:0]         d_out_q, d_out_d;
  logic                rd_strobe, wr_strobe, pop, flush, full, fifo_we;
  logic [1:0]          sel;
  logic                unused_bits;

  assign unused_bits = ^{addr[31:2], d_in[31:17], d_in[15:9], d_in[7:0],
                         32'(REPEAT_DELAY), 32'(REPEAT_RATE)};

  // Two-flop column synchroniser; idle (pulled-up) level is all ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_meta_q <= 4'hF;
      col_sync_q <= 4'hF;
    end else begin
      col_meta_q <= col;
      col_sync_q <= col_meta_q;
    end
  end

  assign wrap     = &presc_q;
  assign scan_end = wrap && (row_idx_q == 2'd3);

  // Row scanning: capture pressed columns of the driven row on each prescaler wrap.
  always_comb begin
    presc_d   = presc_q + 1'b1;
    row_idx_d = row_idx_q;
    raw_d     = raw_q;
    if (wrap) begin
      raw_d[{row_idx_q, 2'b00} +: 4] = ~col_sync_q;
      row_idx_d                      = row_idx_q + 2'd1;
    end
    row_d = ~(4'b0001 << row_idx_d);
  end

  // Debounce at each full-scan boundary; a press is queued once stability first hits DEBOUNCE.
  always_comb begin
    snap_d   = snap_q;
    stable_d = stable_q;
    deb_d    = deb_q;
    new_push = 1'b0;
    new_code = lowest_idx(raw_d & ~deb_q);
    if (scan_end) begin
      snap_d = raw_d;
      if (raw_d == snap_q) begin
        if (stable_q != 4'(DEBOUNCE)) begin
          stable_d = stable_q + 4'd1;
          if (stable_q == 4'(DEBOUNCE - 1)) begin
            deb_d    = raw_d;
            new_push = |(raw_d & ~deb_q);
          end
        end
      end else begin
        stable_d = '0;
      end
    end
  end

`ifdef KEYPAD_REPEAT_EN
  logic [15:0] rep_cnt_q, rep_cnt_d;
  logic        rep_push;

  // Auto-repeat: count scans while a single key stays debounced, re-push on schedule.
  always_comb begin
    rep_cnt_d = rep_cnt_q;
    rep_push  = 1'b0;
    if (scan_end) begin
      if ((deb_d != deb_q) || !$onehot(deb_q)) begin
        rep_cnt_d = '0;
      end else if (rep_cnt_q == 16'(REPEAT_DELAY - 1)) begin
        rep_push  = 1'b1;
        rep_cnt_d = 16'(REPEAT_DELAY - REPEAT_RATE);
      end else begin
        rep_cnt_d = rep_cnt_q + 16'd1;
      end
    end
  end

  // Repeat scan counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rep_cnt_q <= '0;
    else        rep_cnt_q <= rep_cnt_d;
  end

  assign push_req  = new_push | rep_push;
  assign push_code = new_push ? new_code : lowest_idx(deb_q);
`else
  assign push_req  = new_push;
  assign push_code = new_code;
`endif

  assign rd_strobe = strobe && !rw;
  assign wr_strobe = strobe && rw;
  assign sel       = addr[1:0];
  assign pop       = rd_strobe && (sel == 2'd0) && (count_q != '0);
  assign flush     = wr_strobe && (sel == 2'd0);
  assign full      = (count_q == FullCount);

  // FIFO bookkeeping, control register writes and registered read data.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    irq_en_d = irq_en_q;
    fifo_we  = 1'b0;
    d_out_d  = d_out_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // A pop frees a slot in the same cycle, so a full FIFO still accepts the push.
      fifo_we = push_req && (!full || pop);
      if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
      if (fifo_we) wr_ptr_d = wr_ptr_q + 1'b1;
      if (fifo_we && !pop)      count_d = count_q + 1'b1;
      else if (!fifo_we && pop) count_d = count_q - 1'b1;
    end
    if (wr_strobe && (sel == 2'd1)) begin
      if (d_in[8]) ovf_d = 1'b0;
      irq_en_d = d_in[16];
    end
    // New overflow wins over a same-cycle clear.
    if (!flush && push_req && full && !pop) ovf_d = 1'b1;
    if (rd_strobe) begin
      unique case (sel)
        2'd0:    d_out_d = (count_q != '0) ? {1'b1, 27'b0, mem_q[rd_ptr_q]} : 32'd0;
        2'd1:    d_out_d = {15'b0, irq_en_q, 7'b0, ovf_q, 5'b0, 3'(count_q)};
        2'd2:    d_out_d = {16'b0, deb_q};
        default: d_out_d = 32'd0;
      endcase
    end
  end

  assign ack_d = strobe;
  assign irq_d = irq_en_q && (count_q != '0);

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q   <= '0;
      row_idx_q <= '0;
      row_q     <= 4'b1110;
      raw_q     <= '0;
      snap_q    <= '0;
      deb_q     <= '0;
      stable_q  <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      irq_en_q  <= 1'b0;
      irq_q     <= 1'b0;
      ack_q     <= 1'b0;
      d_out_q   <= '0;
    end else begin
      presc_q   <= presc_d;
      row_idx_q <= row_idx_d;
      row_q     <= row_d;
      raw_q     <= raw_d;
      snap_q    <= snap_d;
      deb_q     <= deb_d;
      stable_q  <= stable_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      irq_en_q  <= irq_en_d;
      irq_q     <= irq_d;
      ack_q     <= ack_d;
      d_out_q   <= d_out_d;
    end
  end

  // FIFO storage; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    if (fifo_we) mem_q[wr_ptr_q] <= push_code;
  end

  assign d_out = d_out_q;
  assign ack   = ack_q;
  assign row   = row_q;
  assign irq   = irq_q;

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: table-driven bus vectors with a read scoreboard, plus timed corner sequences.
module tb_keypad_scan;

  localparam int unsigned ScanCyc = 16;  // 4 rows x 2^CNT_BITS clocks

  logic        clk = 1'b0;
  logic        reset, strobe, rw;
  logic [31:0] addr, d_in, d_out;
  logic        ack, irq;
  logic [3:0]  row, col;
  logic [15:0] keys;

  int n_vec = 0;
  int n_fail = 0;

  logic [32:0] sb_q[$];
  string       sb_name_q[$];

  typedef struct {
    logic        rw;
    logic [1:0]  a;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[19];

  keypad_scan #(
    .CNT_BITS(2),
    .DEBOUNCE(2),
    .FIFO_LOG(2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .strobe(strobe),
    .rw    (rw),
    .addr  (addr),
    .d_in  (d_in),
    .d_out (d_out),
    .ack   (ack),
    .row   (row),
    .col   (col),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a pressed key pulls its column low while its row is driven low.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!row[r] && keys[r*4+c]) col[c] = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: each ack retires one access; reads compare d_out.
  always @(negedge clk) begin
    if (reset && ack) begin
      if (sb_q.size() == 0) begin
        check("unexpected_ack", 32'd1, 32'd0);
      end else begin
        logic [32:0] e;
        string       nm;
        e  = sb_q.pop_front();
        nm = sb_name_q.pop_front();
        if (e[32]) check(nm, d_out, e[31:0]);
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_read(input logic [1:0] a, input logic [31:0] exp, input string name);
    sb_q.push_back({1'b1, exp});
    sb_name_q.push_back(name);
    strobe = 1'b1; rw = 1'b0; addr = {30'b0, a};
    @(posedge clk); #1;
    strobe = 1'b0;
    check({name, "_ack"}, {31'b0, ack}, 32'd1);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] data, input string name);
    sb_q.push_back({1'b0, 32'd0});
    sb_name_q.push_back(name);
    strobe = 1'b1; rw = 1'b1; addr = {30'b0, a}; d_in = data;
    @(posedge clk); #1;
    strobe = 1'b0;
    check({name, "_ack"}, {31'b0, ack}, 32'd1);
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      if (vecs[i].rw) bus_write(vecs[i].a, vecs[i].data, $sformatf("vec%0d", i));
      else            bus_read(vecs[i].a, vecs[i].exp, $sformatf("vec%0d", i));
    end
  endtask

  // Press a key, hold, release, let the released state settle.
  task automatic tap(input int code);
    keys = 16'b1 << code;
    wait_cyc(6 * ScanCyc);
    keys = '0;
    wait_cyc(6 * ScanCyc);
  endtask

  // Return just after the edge where row_idx wraps 3 -> 0 (end of a full scan).
  task automatic wait_boundary();
    logic [3:0] prev;
    bit         ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      prev = row;
      @(posedge clk); #1;
      if (prev == 4'b0111 && row == 4'b1110) begin
        ok = 1'b1;
        break;
      end
    end
    check("scan_boundary", {31'b0, ok}, 32'd1);
  endtask

  // Press right after a scan boundary; returns one cycle before the push edge (third boundary).
  task automatic press_aligned(input int code);
    bit ok = 1'b0;
    wait_boundary();
    keys = 16'b1 << code;
    wait_boundary();
    wait_boundary();
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (row == 4'b0111) begin
        ok = 1'b1;
        break;
      end
    end
    check("row3_seen", {31'b0, ok}, 32'd1);
    wait_cyc(3);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // {rw, addr, write data, expected read data}
    vecs[0]  = '{1'b0, 2'd1, 32'h0, 32'h0000_0001};
    vecs[1]  = '{1'b0, 2'd0, 32'h0, 32'h8000_0009};
    vecs[2]  = '{1'b0, 2'd0, 32'h0, 32'h0000_0000};
    vecs[3]  = '{1'b0, 2'd2, 32'h0, 32'h0000_0200};
    vecs[4]  = '{1'b0, 2'd3, 32'h0, 32'h0000_0000};
    vecs[5]  = '{1'b0, 2'd1, 32'h0, 32'h0000_0104};
    vecs[6]  = '{1'b1, 2'd1, 32'h100, 32'h0};
    vecs[7]  = '{1'b0, 2'd1, 32'h0, 32'h0000_0004};
    vecs[8]  = '{1'b0, 2'd0, 32'h0, 32'h8000_0001};
    vecs[9]  = '{1'b0, 2'd0, 32'h0, 32'h8000_0005};
    vecs[10] = '{1'b0, 2'd0, 32'h0, 32'h8000_000A};
    vecs[11] = '{1'b0, 2'd0, 32'h0, 32'h8000_000F};
    vecs[12] = '{1'b0, 2'd1, 32'h0, 32'h0000_0000};
    vecs[13] = '{1'b0, 2'd1, 32'h0, 32'h0000_0004};
    vecs[14] = '{1'b0, 2'd0, 32'h0, 32'h8000_000C};
    vecs[15] = '{1'b0, 2'd0, 32'h0, 32'h8000_000D};
    vecs[16] = '{1'b0, 2'd0, 32'h0, 32'h8000_000E};
    vecs[17] = '{1'b0, 2'd0, 32'h0, 32'h8000_0007};
    vecs[18] = '{1'b0, 2'd1, 32'h0, 32'h0000_0000};

    reset = 1'b0; strobe = 1'b0; rw = 1'b0; addr = '0; d_in = '0; keys = '0;
    wait_cyc(3);
    check("rst_row", {28'b0, row}, 32'h0000_000E);
    check("rst_dout", d_out, 32'h0);
    check("rst_ack", {31'b0, ack}, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    reset = 1'b1;
    wait_cyc(4 * ScanCyc);

    // Single held key 0x9: one push, pop, then empty.
    keys = 16'b1 << 9;
    wait_cyc(10 * ScanCyc);
    run_vecs(0, 4);
    keys = '0;
    wait_cyc(6 * ScanCyc);
    bus_read(2'd2, 32'h0, "deb_released");
    bus_read(2'd1, 32'h0, "count_after_release");

    // Column toggling every full scan never debounces; then a stable hold pushes once.
    for (int i = 0; i < 10; i++) begin
      keys = keys ^ (16'b1 << 6);
      wait_cyc(ScanCyc);
    end
    bus_read(2'd2, 32'h0, "toggle_deb");
    bus_read(2'd1, 32'h0, "toggle_count");
    keys = 16'b1 << 6;
    wait_cyc(6 * ScanCyc);
    bus_read(2'd1, 32'h1, "stable_count");
    bus_read(2'd0, 32'h8000_0006, "stable_code");
    bus_read(2'd0, 32'h0, "stable_empty");
    keys = '0;
    wait_cyc(6 * ScanCyc);

    // Five presses into a 4-deep FIFO: overflow set, clear it, oldest four in order.
    tap(4'h1); tap(4'h5); tap(4'hA); tap(4'hF); tap(4'h3);
    run_vecs(5, 12);

    // Full FIFO with a read landing on the push edge: count stays 4, no overflow.
    tap(4'hB); tap(4'hC); tap(4'hD); tap(4'hE);
    press_aligned(7);
    bus_read(2'd0, 32'h8000_000B, "coincident_pop");
    keys = '0;
    wait_cyc(6 * ScanCyc);
    run_vecs(13, 18);

    // irq rises one cycle after the push; flush drops it the following cycle.
    bus_write(2'd1, 32'h0001_0000, "irq_enable");
    press_aligned(2);
    @(posedge clk); #1;
    check("irq_at_push_edge", {31'b0, irq}, 32'd0);
    @(posedge clk); #1;
    check("irq_after_push", {31'b0, irq}, 32'd1);
    bus_read(2'd1, 32'h0001_0001, "irq_status");
    bus_write(2'd0, 32'h0, "flush");
    check("irq_at_flush_edge", {31'b0, irq}, 32'd1);
    @(posedge clk); #1;
    check("irq_after_flush", {31'b0, irq}, 32'd0);
    bus_read(2'd1, 32'h0001_0000, "status_after_flush");
    keys = '0;
    wait_cyc(6 * ScanCyc);

    // Asynchronous reset mid-scan with a key held and a pending code.
    keys = 16'b1 << 9;
    wait_cyc(6 * ScanCyc + 1);
    check("pre_reset_irq", {31'b0, irq}, 32'd1);
    #3;
    reset = 1'b0;
    #1;
    check("mid_rst_row", {28'b0, row}, 32'h0000_000E);
    check("mid_rst_dout", d_out, 32'h0);
    check("mid_rst_irq", {31'b0, irq}, 32'h0);
    check("mid_rst_ack", {31'b0, ack}, 32'h0);
    wait_cyc(2);
    reset = 1'b1;
    bus_read(2'd1, 32'h0, "post_rst_status");
    wait_cyc(8 * ScanCyc);
    bus_read(2'd1, 32'h1, "redetect_count");
    bus_read(2'd0, 32'h8000_0009, "redetect_code");
    bus_read(2'd0, 32'h0, "redetect_empty");
    keys = '0;
    wait_cyc(4);

    check("scoreboard_drained", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
